// File: rtl/peak_frame_streamer_if.sv
// Stream-side bundle for peak_frame_streamer: frame strobe in, (pixel, peak) words and status out.
interface peak_frame_streamer_if #(
    parameter int NP    = 10,
    parameter int PIX   = 3,
    parameter int IDX_W = 2,
    parameter int CNT_W = 16
);
    logic                peak_valid;
    logic [NP*PIX-1:0]   peak_bus;
    logic                out_valid;
    logic                out_ready;
    logic [IDX_W-1:0]    out_pix;
    logic [NP-1:0]       out_peak;
    logic                out_last;
    logic [CNT_W-1:0]    frame_cnt;
    logic [CNT_W-1:0]    drop_cnt;
    logic                overflow;
    logic                busy;

    modport master (
        output peak_valid, peak_bus, out_ready,
        input  out_valid, out_pix, out_peak, out_last, frame_cnt, drop_cnt, overflow, busy
    );

    modport slave (
        input  peak_valid, peak_bus, out_ready,
        output out_valid, out_pix, out_peak, out_last, frame_cnt, drop_cnt, overflow, busy
    );
endinterface

// File: rtl/peak_frame_streamer.sv
// Ping-pong capture of per-pixel peak bins and valid/ready serialisation as (pixel, peak) words.
module peak_frame_streamer #(
    parameter int NP    = 10,
    parameter int PIX   = 3,
    parameter int IDX_W = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   res,
    peak_frame_streamer_if.slave   bus
);
    typedef enum logic {IDLE, STREAM} state_t;

    state_t                          r_state, w_state_nxt;
    logic [1:0][PIX-1:0][NP-1:0]     r_bank;
    logic [1:0]                      r_occ, w_occ_nxt;
    logic                            r_wr_sel, r_rd_sel;
    logic [IDX_W-1:0]                r_pix;
    logic [NP-1:0]                   r_peak;
    logic                            r_last;
    logic [CNT_W-1:0]                r_frame_cnt, r_drop_cnt;
    logic                            r_overflow;

    logic                            w_hs, w_last, w_rel, w_cap, w_drop;
    logic                            w_load, w_load_bank;
    logic [IDX_W-1:0]                w_load_idx, w_nxt_idx;

    assign w_hs      = (r_state == STREAM) & bus.out_ready;
    assign w_last    = (r_pix == IDX_W'(PIX-1));
    assign w_rel     = w_hs & w_last;
    assign w_nxt_idx = r_pix + 1'b1;
    // A bank finishing its last word this cycle may be refilled in the same cycle.
    assign w_cap     = bus.peak_valid &
                       (~r_occ[r_wr_sel] | (w_rel & (r_rd_sel == r_wr_sel)));
    assign w_drop    = bus.peak_valid & ~w_cap;

    always_comb begin
        w_occ_nxt = r_occ;
        if (w_rel) w_occ_nxt[r_rd_sel] = 1'b0;
        if (w_cap) w_occ_nxt[r_wr_sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_bank = r_rd_sel;
        w_load_idx  = '0;
        case (r_state)
            IDLE: begin
                if (r_occ[r_rd_sel]) begin
                    w_state_nxt = STREAM;
                    w_load      = 1'b1;
                end
            end
            STREAM: begin
                if (w_hs) begin
                    if (!w_last) begin
                        w_load     = 1'b1;
                        w_load_idx = w_nxt_idx;
                    end else if (r_occ[~r_rd_sel]) begin
                        w_load      = 1'b1;
                        w_load_bank = ~r_rd_sel;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            r_bank      <= '0;
            r_occ       <= '0;
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_pix       <= '0;
            r_peak      <= '0;
            r_last      <= 1'b0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            r_occ <= w_occ_nxt;
            if (w_cap) begin
                r_bank[r_wr_sel] <= bus.peak_bus;
                r_wr_sel         <= ~r_wr_sel;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
            end
            if (w_rel) begin
                r_rd_sel    <= ~r_rd_sel;
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
            if (w_load) begin
                r_pix  <= w_load_idx;
                r_peak <= r_bank[w_load_bank][w_load_idx];
                r_last <= (w_load_idx == IDX_W'(PIX-1));
            end
        end
    end

    assign bus.out_valid = (r_state == STREAM);
    assign bus.out_pix   = r_pix;
    assign bus.out_peak  = r_peak;
    assign bus.out_last  = r_last;
    assign bus.frame_cnt = r_frame_cnt;
    assign bus.drop_cnt  = r_drop_cnt;
    assign bus.overflow  = r_overflow;
    assign bus.busy      = |r_occ;
endmodule

// File: tb/tb_peak_frame_streamer.sv
// Directed bench for peak_frame_streamer: single frame, backpressure, ping-pong, drop, same-cycle refill, reset.
module tb_peak_frame_streamer;
    localparam int NP = 10, PIX = 3, IDX_W = 2, CNT_W = 16;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    peak_frame_streamer_if #(.NP(NP), .PIX(PIX), .IDX_W(IDX_W), .CNT_W(CNT_W)) bus ();

    peak_frame_streamer #(.NP(NP), .PIX(PIX), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .res (res),
        .bus (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NP*PIX-1:0] pack(input int p0, input int p1, input int p2);
        logic [NP*PIX-1:0] v;
        v = {NP'(p2), NP'(p1), NP'(p0)};
        return v;
    endfunction

    task automatic word(input string tag, input int pix, input int peak, input bit last);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, ".pix"},   32'(bus.out_pix),   32'(pix));
        chk({tag, ".peak"},  32'(bus.out_peak),  32'(peak));
        chk({tag, ".last"},  32'(bus.out_last),  32'(last));
    endtask

    task automatic strobe(input logic [NP*PIX-1:0] v);
        bus.peak_valid = 1'b1;
        bus.peak_bus   = v;
        tick();
        bus.peak_valid = 1'b0;
    endtask

    initial begin
        bus.peak_valid = 1'b0;
        bus.peak_bus   = '0;
        bus.out_ready  = 1'b0;
        #12;
        chk("rst.valid", 32'(bus.out_valid), 0);
        chk("rst.busy",  32'(bus.busy), 0);
        chk("rst.fcnt",  32'(bus.frame_cnt), 0);
        chk("rst.ovf",   32'(bus.overflow), 0);
        res = 1'b0;
        tick();

        // single frame, ready high
        bus.out_ready = 1'b1;
        strobe(pack(108, 511, 1022));
        chk("t1.cap.valid", 32'(bus.out_valid), 0);
        chk("t1.cap.busy",  32'(bus.busy), 1);
        tick(); word("t1.w0", 0, 108, 0);
        tick(); word("t1.w1", 1, 511, 0);
        tick(); word("t1.w2", 2, 1022, 1);
        tick();
        chk("t1.idle", 32'(bus.out_valid), 0);
        chk("t1.fcnt", 32'(bus.frame_cnt), 1);
        chk("t1.busy", 32'(bus.busy), 0);

        // backpressure: word 0 held for 5 cycles
        bus.out_ready = 1'b0;
        strobe(pack(108, 511, 1022));
        tick();
        for (int i = 0; i < 5; i++) begin
            word("t2.hold", 0, 108, 0);
            tick();
        end
        word("t2.w0", 0, 108, 0);
        bus.out_ready = 1'b1;
        tick(); word("t2.w1", 1, 511, 0);
        tick(); word("t2.w2", 2, 1022, 1);
        tick();
        chk("t2.idle", 32'(bus.out_valid), 0);
        chk("t2.fcnt", 32'(bus.frame_cnt), 2);

        // ping-pong: B two cycles after A, no bubble
        strobe(pack(1, 2, 3));
        tick(); word("t3.w1", 0, 1, 0);
        bus.peak_valid = 1'b1; bus.peak_bus = pack(4, 5, 6);
        tick(); word("t3.w2", 1, 2, 0);
        bus.peak_valid = 1'b0;
        tick(); word("t3.w3", 2, 3, 1);
        tick(); word("t3.w4", 0, 4, 0);
        tick(); word("t3.w5", 1, 5, 0);
        tick(); word("t3.w6", 2, 6, 1);
        tick();
        chk("t3.idle", 32'(bus.out_valid), 0);
        chk("t3.fcnt", 32'(bus.frame_cnt), 4);

        // overflow: third frame dropped while both banks held
        bus.out_ready = 1'b0;
        strobe(pack(10, 11, 12));
        strobe(pack(20, 21, 22));
        strobe(pack(30, 31, 32));
        chk("t4.drop", 32'(bus.drop_cnt), 1);
        chk("t4.ovf",  32'(bus.overflow), 1);
        word("t4.a0", 0, 10, 0);
        bus.out_ready = 1'b1;
        tick(); word("t4.a1", 1, 11, 0);
        tick(); word("t4.a2", 2, 12, 1);
        tick(); word("t4.b0", 0, 20, 0);
        tick(); word("t4.b1", 1, 21, 0);
        tick(); word("t4.b2", 2, 22, 1);
        tick();
        chk("t4.idle", 32'(bus.out_valid), 0);
        chk("t4.ovf2", 32'(bus.overflow), 1);
        chk("t4.fcnt", 32'(bus.frame_cnt), 6);

        // refill bank0 on its own last handshake
        bus.out_ready = 1'b0;
        strobe(pack(40, 41, 42));
        strobe(pack(50, 51, 52));
        word("t5.x0", 0, 40, 0);
        bus.out_ready = 1'b1;
        tick(); word("t5.x1", 1, 41, 0);
        tick(); word("t5.x2", 2, 42, 1);
        bus.peak_valid = 1'b1; bus.peak_bus = pack(60, 61, 62);
        tick(); word("t5.y0", 0, 50, 0);
        bus.peak_valid = 1'b0;
        chk("t5.drop", 32'(bus.drop_cnt), 1);
        tick(); word("t5.y1", 1, 51, 0);
        tick(); word("t5.y2", 2, 52, 1);
        tick(); word("t5.z0", 0, 60, 0);
        tick(); word("t5.z1", 1, 61, 0);
        tick(); word("t5.z2", 2, 62, 1);
        tick();
        chk("t5.idle", 32'(bus.out_valid), 0);
        chk("t5.fcnt", 32'(bus.frame_cnt), 9);

        // boundary values, then asynchronous reset mid-frame
        strobe(pack(0, 1023, 5));
        tick(); word("t6.w0", 0, 0, 0);
        tick(); word("t6.w1", 1, 1023, 0);
        #2 res = 1'b1;
        #1;
        chk("t6.valid", 32'(bus.out_valid), 0);
        chk("t6.pix",   32'(bus.out_pix), 0);
        chk("t6.peak",  32'(bus.out_peak), 0);
        chk("t6.fcnt",  32'(bus.frame_cnt), 0);
        chk("t6.drop",  32'(bus.drop_cnt), 0);
        chk("t6.ovf",   32'(bus.overflow), 0);
        chk("t6.busy",  32'(bus.busy), 0);
        #2 res = 1'b0;
        tick();
        strobe(pack(80, 81, 82));
        tick(); word("t6.n0", 0, 80, 0);
        tick(); word("t6.n1", 1, 81, 0);
        tick(); word("t6.n2", 2, 82, 1);
        tick();
        chk("t6.fcnt2", 32'(bus.frame_cnt), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/peak_frame_streamer.md
Name: peak_frame_streamer

Overview:
- Sits directly downstream of hisBuilderFSM.
- Captures each completed set of per-pixel peak bins into a two-bank (ping-pong) buffer, whenever the builder pulses a frame-valid strobe.
- Serialises the captured bins as a valid/ready stream of (pixel index, peak bin) words for the depth/readout interface.
- Absorbs backpressure for one full frame and flags loss when a third frame arrives before a bank frees.

Parameters:
- NP, 10, peak bin width in bits (matches `Np).
- PIX, 3, pixels per frame (matches `PIXEL_NUM_PER_RAM); must be >= 2.
- IDX_W, 2, pixel-index width; must satisfy 2^IDX_W >= PIX.
- CNT_W, 16, width of the frame and drop counters.

Ports:
- clk, input, 1, system clock; all flops are rising-edge.
- res, input, 1, asynchronous active-high reset.
- peak_valid, input, 1, single-cycle strobe: peak_bus holds a complete frame.
- peak_bus, input, NP*PIX, flattened peaks; pixel i occupies [i*NP +: NP].
- out_valid, output, 1, stream word valid.
- out_ready, input, 1, downstream accepts the word.
- out_pix, output, IDX_W, pixel index of the current word.
- out_peak, output, NP, peak bin of the current word.
- out_last, output, 1, high on pixel PIX-1 of a frame.
- frame_cnt, output, CNT_W, number of frames fully streamed; wraps.
- drop_cnt, output, CNT_W, number of frames dropped; saturates at all-ones.
- overflow, output, 1, sticky; set on the first drop, cleared only by res.
- busy, output, 1, high when any bank is occupied.

Behaviour:
- Reset: while res=1, asynchronously clear all registers, regardless of activity in progress.
  - Outputs go to: out_valid 0, out_pix 0, out_peak 0, out_last 0, frame_cnt 0, drop_cnt 0, overflow 0, busy 0.
  - Banks are emptied; wr_sel=0, rd_sel=0. Any in-flight frame is discarded.
- Storage: bank0 and bank1, each PIX x NP, each with an occupied flag.
  - wr_sel points to the next bank to fill; rd_sel points to the oldest occupied bank.
- Capture, on a cycle with peak_valid=1:
  - If bank[wr_sel] is free, or is being released this same cycle, latch peak_bus into it, set occupied, and toggle wr_sel.
  - Otherwise drop the frame: increment drop_cnt (saturating), set overflow, leave banks untouched.
- Read FSM, two states:
  - IDLE: out_valid=0. Go to STREAM when bank[rd_sel] is occupied, with pix_idx=0.
  - STREAM: out_valid=1; out_pix=pix_idx; out_peak=bank[rd_sel][pix_idx]; out_last=(pix_idx==PIX-1).
  - Handshake with pix_idx<PIX-1: pix_idx+1.
  - Handshake with pix_idx==PIX-1:
    - clear bank[rd_sel] occupied, toggle rd_sel, frame_cnt+1 (wrap);
    - stay in STREAM with pix_idx=0 if the other bank is occupied; otherwise go to IDLE.
  - Handshake means out_valid & out_ready.
- Output registers:
  - out_pix, out_peak and out_last are registered and change only on a handshake or on the IDLE->STREAM transition.
  - While out_valid=1 and out_ready=0, all output fields stay stable.
  - out_valid never drops without a handshake.
- Latency:
  - peak_valid at edge t into an empty block gives out_valid=1 with pixel 0 after edge t+1.
  - With out_ready held high, one word per cycle, so a frame takes PIX cycles.
  - Back-to-back frames stream without a bubble.
- Simultaneous events:
  - A capture into bank B in the same cycle as the final handshake of bank B is legal. The new frame is written and B stays occupied. The frame is queued behind the other bank if that bank is occupied.
  - Peak values of 0 and 2^NP-1 are streamed unmodified; there is no value filtering.
- busy = occupied0 | occupied1.
- out_ready is ignored while out_valid=0.

Test Plan:
- Single frame: res pulse, then peak_valid with bins {p0=108, p1=511, p2=1022}, out_ready=1 → words (0,108), (1,511), (2,1022,last) on three consecutive cycles; first word one cycle after capture; frame_cnt=1; busy falls after the last word.
- Backpressure: same frame, out_ready=0 for 5 cycles then 1 → word (0,108) held stable for 5 cycles, then the sequence continues; no duplicated or skipped index.
- Ping-pong: frame A {1,2,3} and, 2 cycles later, frame B {4,5,6}, out_ready=1 → six words 1..6 contiguous; out_last on 3 and 6; frame_cnt=2.
- Overflow: out_ready=0, three peak_valid strobes (A, B, C) → C dropped; drop_cnt=1, overflow=1. Release ready → A then B stream; C never appears; overflow stays 1.
- Same-cycle release and capture: both banks full; peak_valid asserted on the last handshake of bank0 → no drop; bank0 refilled and streams after bank1.
- Reset mid-stream: assert res during pixel 1 of a frame → all outputs 0 immediately (asynchronous), counters cleared; next frame after deassertion streams from pixel 0.
